// File: rtl/mem_access_controller.sv
// MEM-stage data memory access controller.
// Issues word/byte loads and stores over a req/ack handshake, stalls the
// upstream pipeline while an access is outstanding, aligns load data and
// produces the MEM/WB pipeline register contents. Hung accesses are
// aborted after TIMEOUT_CYCLES cycles in REQ.
module mem_access_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        MEM_valid,
  input  logic        MEM_load_instr,
  input  logic        MEM_mem_read_write,
  input  logic        MEM_mem_size,
  input  logic        MEM_RF_Enable,
  input  logic [31:0] MEM_A_O,
  input  logic [31:0] MEM_MUX3,
  input  logic [3:0]  MEM_Bit15_12,
  output logic        dm_req,
  output logic        dm_rw,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] WB_A_O,
  output logic [31:0] WB_Data_RAM_Out,
  output logic [3:0]  WB_Bit15_12,
  output logic        WB_load_instr,
  output logic        WB_RF_Enable,
  output logic        misalign_fault,
  output logic        bus_error
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               rw_q, rw_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [1:0]         lane_q, lane_d;
  logic               byte_q, byte_d;
  logic [31:0]        wb_a_o_q, wb_a_o_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [3:0]         wb_dst_q, wb_dst_d;
  logic               wb_load_q, wb_load_d;
  logic               wb_rfen_q, wb_rfen_d;
  logic               misalign_q, misalign_d;
  logic               bus_err_q, bus_err_d;

  logic               mem_op;
  logic               misaligned;
  logic               start_access;
  logic               timeout_hit;
  logic               wb_bubble;
  logic [31:0]        load_data;

  // Decode the instruction in EX/MEM and the abort condition.
  always_comb begin
    mem_op       = MEM_valid & (MEM_load_instr | MEM_mem_read_write);
    misaligned   = mem_op & ~MEM_mem_size & (MEM_A_O[1:0] != 2'b00);
    start_access = (state_q == IDLE) & mem_op & ~misaligned;
    timeout_hit  = (state_q == REQ) & ~dm_ack & (cnt_q == CNT_LAST);
    mem_stall    = start_access | ((state_q == REQ) & ~dm_ack & ~timeout_hit);
    wb_bubble    = mem_stall | timeout_hit | ((state_q == IDLE) & misaligned);
  end

  // Little-endian load alignment using the lane captured at issue.
  always_comb begin
    load_data = dm_rdata;
    if (byte_q) begin
      load_data = {24'b0, dm_rdata[{lane_q, 3'b000} +: 8]};
    end
  end

  // Next-state, memory request and WB register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    lane_d     = lane_q;
    byte_d     = byte_q;
    wb_a_o_d   = wb_a_o_q;
    wb_data_d  = wb_data_q;
    wb_dst_d   = wb_dst_q;
    wb_load_d  = wb_load_q;
    wb_rfen_d  = wb_rfen_q;
    misalign_d = 1'b0;
    bus_err_d  = bus_err_q;

    unique case (state_q)
      IDLE: begin
        if (start_access) begin
          state_d = REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          rw_d    = MEM_mem_read_write;
          addr_d  = {MEM_A_O[31:2], 2'b00};
          lane_d  = MEM_A_O[1:0];
          byte_d  = MEM_mem_size;
          if (MEM_mem_size) begin
            wdata_d = {4{MEM_MUX3[7:0]}};
            be_d    = 4'b0001 << MEM_A_O[1:0];
          end else begin
            wdata_d = MEM_MUX3;
            be_d    = 4'b1111;
          end
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end
      end
      REQ: begin
        if (dm_ack) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          wb_data_d = load_data;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Bubble keeps data fields, kills the write-back controls.
    if (wb_bubble) begin
      wb_rfen_d = 1'b0;
      wb_load_d = 1'b0;
    end else begin
      wb_a_o_d  = MEM_A_O;
      wb_dst_d  = MEM_Bit15_12;
      wb_load_d = MEM_valid & MEM_load_instr;
      wb_rfen_d = MEM_valid & MEM_RF_Enable;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lane_q     <= '0;
      byte_q     <= 1'b0;
      wb_a_o_q   <= '0;
      wb_data_q  <= '0;
      wb_dst_q   <= '0;
      wb_load_q  <= 1'b0;
      wb_rfen_q  <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      lane_q     <= lane_d;
      byte_q     <= byte_d;
      wb_a_o_q   <= wb_a_o_d;
      wb_data_q  <= wb_data_d;
      wb_dst_q   <= wb_dst_d;
      wb_load_q  <= wb_load_d;
      wb_rfen_q  <= wb_rfen_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dm_req          = req_q;
  assign dm_rw           = rw_q;
  assign dm_addr         = addr_q;
  assign dm_wdata        = wdata_q;
  assign dm_be           = be_q;
  assign WB_A_O          = wb_a_o_q;
  assign WB_Data_RAM_Out = wb_data_q;
  assign WB_Bit15_12     = wb_dst_q;
  assign WB_load_instr   = wb_load_q;
  assign WB_RF_Enable    = wb_rfen_q;
  assign misalign_fault  = misalign_q;
  assign bus_error       = bus_err_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: directed cases plus
// randomized instructions against a transaction-level reference model.
module tb_mem_access_controller;

  localparam int unsigned T = 4;

  logic        clk;
  logic        Reset;
  logic        MEM_valid;
  logic        MEM_load_instr;
  logic        MEM_mem_read_write;
  logic        MEM_mem_size;
  logic        MEM_RF_Enable;
  logic [31:0] MEM_A_O;
  logic [31:0] MEM_MUX3;
  logic [3:0]  MEM_Bit15_12;
  logic        dm_req;
  logic        dm_rw;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic [31:0] WB_A_O;
  logic [31:0] WB_Data_RAM_Out;
  logic [3:0]  WB_Bit15_12;
  logic        WB_load_instr;
  logic        WB_RF_Enable;
  logic        misalign_fault;
  logic        bus_error;

  int n_vec;
  int n_err;
  bit bus_err_m;

  mem_access_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .Reset              (Reset),
    .MEM_valid          (MEM_valid),
    .MEM_load_instr     (MEM_load_instr),
    .MEM_mem_read_write (MEM_mem_read_write),
    .MEM_mem_size       (MEM_mem_size),
    .MEM_RF_Enable      (MEM_RF_Enable),
    .MEM_A_O            (MEM_A_O),
    .MEM_MUX3           (MEM_MUX3),
    .MEM_Bit15_12       (MEM_Bit15_12),
    .dm_req             (dm_req),
    .dm_rw              (dm_rw),
    .dm_addr            (dm_addr),
    .dm_wdata           (dm_wdata),
    .dm_be              (dm_be),
    .dm_ack             (dm_ack),
    .dm_rdata           (dm_rdata),
    .mem_stall          (mem_stall),
    .WB_A_O             (WB_A_O),
    .WB_Data_RAM_Out    (WB_Data_RAM_Out),
    .WB_Bit15_12        (WB_Bit15_12),
    .WB_load_instr      (WB_load_instr),
    .WB_RF_Enable       (WB_RF_Enable),
    .misalign_fault     (misalign_fault),
    .bus_error          (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One instruction from presentation until the pipeline advances past it.
  // waits = REQ cycles without ack before the responder acks.
  task automatic do_op(input bit valid, input bit load, input bit rw, input bit size,
                       input bit rfen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [3:0] dst, input int waits);
    bit          mem_op, mis, acc, tmo, bubble, done;
    int          exp_stall, exp_req, stall_cnt, req_cnt;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    logic [3:0]  exp_be;
    int          sh;

    mem_op   = valid && (load || rw);
    mis      = mem_op && !size && (a[1:0] != 2'b00);
    acc      = mem_op && !mis;
    tmo      = acc && (waits >= int'(T));
    bubble   = mis || tmo;
    exp_req  = !acc ? 0 : (tmo ? int'(T) : waits + 1);
    exp_stall = exp_req;
    exp_addr = {a[31:2], 2'b00};
    sh       = int'(a[1:0]) * 8;
    exp_be   = size ? (4'b0001 << a[1:0]) : 4'b1111;
    exp_wdata = size ? {4{wd[7:0]}} : wd;
    exp_data = size ? ((rd >> sh) & 32'hFF) : rd;
    if (tmo) bus_err_m = 1'b1;

    MEM_valid          = valid;
    MEM_load_instr     = load;
    MEM_mem_read_write = rw;
    MEM_mem_size       = size;
    MEM_RF_Enable      = rfen;
    MEM_A_O            = a;
    MEM_MUX3           = wd;
    MEM_Bit15_12       = dst;

    stall_cnt = 0;
    req_cnt   = 0;
    done      = 1'b0;
    for (int c = 0; c < 64; c++) begin
      dm_ack   = dm_req && (req_cnt == waits);
      dm_rdata = dm_ack ? rd : $urandom;
      @(negedge clk);
      if (dm_req) begin
        check_eq("dm_addr", dm_addr, exp_addr);
        check_eq("dm_be", 32'(dm_be), 32'(exp_be));
        check_eq("dm_rw", 32'(dm_rw), 32'(rw));
        if (rw) check_eq("dm_wdata", dm_wdata, exp_wdata);
        req_cnt++;
      end
      if (mem_stall) stall_cnt++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (done) break;
    end

    check_eq("op_done", 32'(done), 32'd1);
    check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check_eq("req_cycles", 32'(req_cnt), 32'(exp_req));
    check_eq("dm_req_after", 32'(dm_req), 32'd0);
    check_eq("misalign_fault", 32'(misalign_fault), 32'(mis));
    check_eq("bus_error", 32'(bus_error), 32'(bus_err_m));
    check_eq("wb_rf_enable", 32'(WB_RF_Enable), 32'(!bubble && valid && rfen));
    check_eq("wb_load_instr", 32'(WB_load_instr), 32'(!bubble && valid && load));
    if (!bubble) begin
      check_eq("wb_a_o", WB_A_O, a);
      check_eq("wb_bit15_12", 32'(WB_Bit15_12), 32'(dst));
      if (acc && load) check_eq("wb_data", WB_Data_RAM_Out, exp_data);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_dm_req"}, 32'(dm_req), 32'd0);
    check_eq({tag, "_dm_rw"}, 32'(dm_rw), 32'd0);
    check_eq({tag, "_dm_be"}, 32'(dm_be), 32'd0);
    check_eq({tag, "_dm_addr"}, dm_addr, 32'd0);
    check_eq({tag, "_dm_wdata"}, dm_wdata, 32'd0);
    check_eq({tag, "_wb_a_o"}, WB_A_O, 32'd0);
    check_eq({tag, "_wb_data"}, WB_Data_RAM_Out, 32'd0);
    check_eq({tag, "_wb_dst"}, 32'(WB_Bit15_12), 32'd0);
    check_eq({tag, "_wb_load"}, 32'(WB_load_instr), 32'd0);
    check_eq({tag, "_wb_rfen"}, 32'(WB_RF_Enable), 32'd0);
    check_eq({tag, "_misalign"}, 32'(misalign_fault), 32'd0);
    check_eq({tag, "_bus_error"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    bit          ld, st, sz, vld;
    logic [31:0] a;
    int          kind, w;

    n_vec = 0;
    n_err = 0;
    bus_err_m = 1'b0;
    Reset = 1'b1;
    MEM_valid = 1'b0;
    MEM_load_instr = 1'b0;
    MEM_mem_read_write = 1'b0;
    MEM_mem_size = 1'b0;
    MEM_RF_Enable = 1'b0;
    MEM_A_O = '0;
    MEM_MUX3 = '0;
    MEM_Bit15_12 = '0;
    dm_ack = 1'b0;
    dm_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    Reset = 1'b0;

    // Directed cases from the block's test plan.
    do_op(1, 1, 0, 0, 1, 32'h10, 32'h0, 32'hDEADBEEF, 4'd3, 0);
    do_op(1, 1, 0, 1, 1, 32'h13, 32'h0, 32'hAABBCCDD, 4'd5, 1);
    do_op(1, 0, 1, 1, 0, 32'h21, 32'h12345678, 32'h0, 4'd0, 2);
    do_op(1, 0, 0, 0, 1, 32'h44, 32'h0, 32'h0, 4'd7, 0);
    do_op(1, 1, 0, 0, 1, 32'h50, 32'h0, 32'h0, 4'd9, 10);
    do_op(1, 0, 0, 0, 1, 32'h58, 32'h0, 32'h0, 4'd2, 0);
    do_op(1, 1, 0, 0, 1, 32'h60, 32'h0, 32'h01020304, 4'd4, int'(T) - 1);
    do_op(1, 1, 0, 0, 1, 32'h06, 32'h0, 32'h0, 4'd6, 0);
    do_op(0, 0, 0, 0, 1, 32'h70, 32'h0, 32'h0, 4'd1, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
      sz   = 1'($urandom);
      vld  = 1'b1;
      ld   = (kind == 1) || (kind == 3);
      st   = (kind == 2);
      if (kind == 0) begin
        vld = ($urandom_range(0, 3) != 0);
        sz  = 1'b0;
      end
      if (!sz && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
      w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      do_op(vld, ld, st, sz, 1'($urandom), a, $urandom, $urandom, 4'($urandom), w);
    end

    // Reset during the second REQ cycle; a late ack must be ignored.
    MEM_valid = 1'b1;
    MEM_load_instr = 1'b1;
    MEM_mem_read_write = 1'b0;
    MEM_mem_size = 1'b0;
    MEM_RF_Enable = 1'b1;
    MEM_A_O = 32'h80;
    MEM_Bit15_12 = 4'd8;
    dm_ack = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_req_active", 32'(dm_req), 32'd1);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    bus_err_m = 1'b0;
    MEM_valid = 1'b0;
    MEM_load_instr = 1'b0;
    MEM_RF_Enable = 1'b0;
    dm_ack = 1'b1;
    dm_rdata = 32'hCAFEF00D;
    check_reset_state("rst_mid");
    @(negedge clk);
    check_eq("rst_mid_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    dm_ack = 1'b0;
    check_eq("rst_ack_dm_req", 32'(dm_req), 32'd0);
    check_eq("rst_ack_wb_rfen", 32'(WB_RF_Enable), 32'd0);
    check_eq("rst_ack_wb_data", WB_Data_RAM_Out, 32'd0);
    check_eq("rst_ack_bus_error", 32'(bus_error), 32'd0);

    do_op(1, 1, 0, 0, 1, 32'h90, 32'h0, 32'h55AA55AA, 4'd11, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
